// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch front-end.
//
// Issues PC-sequential requests to instruction memory, buffers returned words
// with their PCs in a DEPTH-entry FIFO and presents the head entry to the
// datapath as InstrF/PCF/FetchValidF. Redirects (PCSrcE) flush the FIFO and
// mark every outstanding request as stale so its response is dropped.
//
// Compile-time option: define IFQ_BYPASS_EN to let a response arriving into
// an empty queue drive InstrF/PCF/FetchValidF combinationally in the same
// cycle. Without it, every response lands in the FIFO first and is visible
// on the following cycle (no combinational path from ImemRsp* to outputs).
//
// Handshake semantics (all channels):
//   - Request: a transfer happens on a rising edge where ImemReqValid and
//     ImemReqReady are both 1. ImemReqValid depends only on internal credit
//     state (and reset), never on ImemReqReady or PCSrcE. ImemAddr is stable
//     while ImemReqValid is 1 and no transfer happens.
//   - Response: ImemRspValid carries no back-pressure; exactly one response
//     per accepted request, in order, at least one cycle after acceptance.
//   - Fetch output: the head entry is consumed on an edge where FetchValidF
//     is 1, StallF is 0 and PCSrcE is 0.
//
// Debug outputs dbg_occ / dbg_inflight / dbg_drop expose the FIFO occupancy,
// outstanding-request count and stale-response count.

module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   ImemReqValid,
  input  logic                   ImemReqReady,
  output logic [31:0]            ImemAddr,
  input  logic                   ImemRspValid,
  input  logic [31:0]            ImemRspData,
  input  logic                   StallF,
  input  logic                   PCSrcE,
  input  logic [31:0]            PCTargetE,
  output logic [31:0]            InstrF,
  output logic [31:0]            PCF,
  output logic                   FetchValidF,
  output logic [$clog2(DEPTH):0] dbg_occ,
  output logic [$clog2(DEPTH):0] dbg_inflight,
  output logic [$clog2(DEPTH):0] dbg_drop
);

  localparam int          AW  = $clog2(DEPTH);
  localparam int          CW  = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Fetch PC (next address to request) and response PC (PC of the next
  // non-stale response). After a redirect all non-stale requests are
  // sequential from the target, so one counter tracks response PCs.
  logic [31:0]   fpc;
  logic [31:0]   rpc;

  // FIFO storage and bookkeeping.
  logic [31:0]   pc_mem  [DEPTH];
  logic [31:0]   ins_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] occ;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop;

  logic [CW-1:0] occ_nxt;
  logic [CW-1:0] inflight_nxt;
  logic [CW-1:0] drop_nxt;

  logic [CW:0]   used;
  logic          credit;
  logic          req_fire;
  logic          rsp_keep;
  logic          fifo_valid;
  logic          push;
  logic          pop;

  // Credits cover both stored entries and requests still in flight, so a
  // response can never find the FIFO full.
  assign used     = {1'b0, occ} + {1'b0, inflight};
  assign credit   = (used < (CW+1)'(DEPTH));

  // Requests are held off only while reset is asserted; the redirect does
  // not gate them, a request accepted during a redirect is counted as stale.
  assign ImemReqValid = reset & credit;
  assign ImemAddr     = fpc;
  assign req_fire     = ImemReqValid & ImemReqReady;

  // A response survives when no stale responses are pending and no redirect
  // is flushing the queue in this cycle.
  assign rsp_keep   = ImemRspValid & (drop == '0) & ~PCSrcE;
  assign fifo_valid = (occ != '0);

`ifdef IFQ_BYPASS_EN
  logic byp_valid;

  // Empty queue: the arriving word is shown directly and only stored if the
  // datapath does not take it this cycle.
  assign byp_valid   = rsp_keep & ~fifo_valid;
  assign FetchValidF = fifo_valid | byp_valid;
  assign InstrF      = fifo_valid ? ins_mem[rd_ptr] : (byp_valid ? ImemRspData : NOP);
  assign PCF         = fifo_valid ? pc_mem[rd_ptr]  : (byp_valid ? rpc : fpc);
  assign push        = rsp_keep & ~(byp_valid & ~StallF);
  assign pop         = fifo_valid & ~StallF & ~PCSrcE;
`else
  assign FetchValidF = fifo_valid;
  assign InstrF      = fifo_valid ? ins_mem[rd_ptr] : NOP;
  assign PCF         = fifo_valid ? pc_mem[rd_ptr]  : fpc;
  assign push        = rsp_keep;
  assign pop         = fifo_valid & ~StallF & ~PCSrcE;
`endif

  assign dbg_occ      = occ;
  assign dbg_inflight = inflight;
  assign dbg_drop     = drop;

  // Next-state for the three counters; a redirect overrides push and pop.
  always_comb begin
    inflight_nxt = inflight + CW'(req_fire) - CW'(ImemRspValid);
    occ_nxt      = occ;
    drop_nxt     = drop;
    if (PCSrcE) begin
      occ_nxt  = '0;
      // Everything still outstanding after this edge is stale.
      drop_nxt = inflight_nxt;
    end else begin
      occ_nxt = occ + CW'(push) - CW'(pop);
      if (ImemRspValid && (drop != '0)) begin
        drop_nxt = drop - CW'(1);
      end
    end
  end

  // Control state: PCs, pointers and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc      <= RESET_PC;
      rpc      <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      inflight <= '0;
      drop     <= '0;
    end else begin
      occ      <= occ_nxt;
      inflight <= inflight_nxt;
      drop     <= drop_nxt;
      if (PCSrcE) begin
        fpc    <= PCTargetE;
        rpc    <= PCTargetE;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (req_fire) begin
          fpc <= fpc + 32'd4;
        end
        if (rsp_keep) begin
          rpc <= rpc + 32'd4;
        end
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
      end
    end
  end

  // FIFO payload write; contents need no reset because occ qualifies them.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= rpc;
      ins_mem[wr_ptr] <= ImemRspData;
    end
  end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction fetch front-end for the pipelined RISC-V core, sitting directly upstream of the datapath's Fetch/Decode boundary. It issues PC-sequential requests to instruction memory over a valid/ready handshake and buffers returned words with their PCs in a small FIFO. It presents the head entry to the datapath as `InstrF`/`PCF`, honours `StallF`, and flushes on taken branches or jumps (`PCSrcE`/`PCTargetE`), discarding stale in-flight responses.

## Interface
- `DEPTH`, 4: FIFO entries; also the maximum of stored plus outstanding requests (power of 2, ≥2).
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; 0 resets all state immediately.
- `ImemReqValid`  out  1  request valid.
- `ImemReqReady`  in  1  memory accepts the request when `ImemReqValid` is also 1.
- `ImemAddr`  out  32  request address, word aligned.
- `ImemRspValid`  in  1  response valid; in order, one per accepted request, at least 1 cycle after acceptance.
- `ImemRspData`  in  32  instruction word.
- `StallF`  in  1  datapath not consuming this cycle.
- `PCSrcE`  in  1  redirect request.
- `PCTargetE`  in  32  redirect address.
- `InstrF`  out  32  head instruction; 32'h0000_0013 (NOP) when the queue is empty.
- `PCF`  out  32  head PC; the fetch PC register when the queue is empty.
- `FetchValidF`  out  1  head entry valid; the hazard unit treats 0 as a bubble.

## Operation
- State:
  - fetch PC register `fpc`.
  - FIFO of {PC, instr} with read/write pointers and an occupancy count `occ`.
  - outstanding-request counter `inflight`.
  - stale-response counter `drop`.
- Issue: `ImemReqValid = (occ + inflight < DEPTH)`; `ImemAddr = fpc`. On accept, `fpc += 4` (32-bit wrap) and `inflight++`.
- Response: `inflight--`.
  - If `drop > 0`: the word is discarded and `drop--`.
  - Otherwise the word is pushed with its PC. A PC shadow FIFO or PC counter must track accepted addresses.
- Consume: pop the head when `FetchValidF && !StallF`.
- Redirect (`PCSrcE=1`) has priority over consume and push in the same cycle:
  - FIFO is emptied and `fpc <= PCTargetE`.
  - `drop <= inflight` plus the same-cycle accepted request, minus the same-cycle response.
  - The same-cycle response is discarded.
  - `ImemReqValid` is not gated by `PCSrcE`; a request accepted in the redirect cycle carries the old address and is counted as stale.
- Simultaneous push and pop on a non-empty queue: `occ` is unchanged.
- Push into a full queue cannot occur; the credit rule forbids it. Verification asserts this.
- `StallF` does not stop issuing. Fetch continues until credits are exhausted.

## Timing
- Reset values:
  - `ImemReqValid=0` while reset is asserted; it is 1 in the first cycle after release.
  - `ImemAddr=RESET_PC`, `FetchValidF=0`, `InstrF=32'h13`, `PCF=RESET_PC`.
  - `occ`, `inflight`, `drop` all 0.
- Instruction memory must be reset together with this block. Responses to pre-reset requests are illegal.
- Response to `FetchValidF` latency is 1 cycle (registered FIFO) unless bypass is compiled in.
- Redirect: `FetchValidF=0` in the cycle after `PCSrcE`. The request for `PCTargetE` is issued in that same cycle if a credit is free.
- Throughput: one instruction per cycle sustained, given 1-cycle memory latency and `ImemReqReady=1`.

## Configuration
- `IFQ_BYPASS_EN` defined:
  - A non-discarded response arriving while `occ==0` drives `InstrF`/`PCF`/`FetchValidF` combinationally in the same cycle.
  - If it is consumed that cycle (`!StallF`, no redirect), it is not written to the FIFO.
- Undefined: every response is written to the FIFO and becomes visible the next cycle. There is no combinational path from `ImemRsp*` to the outputs.

## Test plan
- Release reset; `ImemReqReady=1`; 1-cycle response; `StallF=0` → `FetchValidF` rises and `PCF` runs 0x0, 0x4, 0x8, … with `InstrF` matching the memory contents, one per cycle.
- Hold `StallF=1` for 10 cycles → `occ` reaches 4 and `ImemReqValid` drops with `occ+inflight=4`; `PCF` holds 0x0. Release → 0x0, 0x4, 0x8, 0xC appear in order with no loss or duplication.
- 3-cycle memory latency with 2 requests in flight; pulse `PCSrcE` with `PCTargetE=0x100` → both stale responses dropped, the next `FetchValidF=1` shows `PCF=0x100`, and no PC 0x8/0xC entry is ever presented.
- `PCSrcE=1`, `ImemRspValid=1`, `StallF=0` and a full queue in the same cycle → queue empty next cycle, the response is discarded, no pop is counted, and `drop` is correct.
- Assert `reset=0` mid-stream, asynchronously between edges → outputs reach their reset values immediately. After release, fetch restarts at `RESET_PC`.
- With `IFQ_BYPASS_EN`: empty queue, response word 0x00500093 at cycle t → `FetchValidF=1`, `InstrF=0x00500093` at t. Without the macro → at t+1.
